// File: rtl/ntt_core_wmm_unfold_pcg_tail_outbuf.sv
// Tail output buffer: register FIFO turning CLBU avail beats into per-lane vld/rdy.
// Define NTT_TAIL_OUTBUF_OUT_REG_EN to add a 2-entry flop skid stage at the outputs.
module ntt_core_wmm_unfold_pcg_tail_outbuf #(
    parameter int OP_W      = 32,
    parameter int R         = 2,
    parameter int PSI       = 4,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4,
    parameter int BPBS_ID_W = 8
) (
    input  logic                            clk,
    input  logic                            s_rst,
    input  logic [PSI-1:0][R-1:0][OP_W-1:0] clbu_tail_data,
    input  logic [PSI-1:0]                  clbu_tail_data_avail,
    input  logic                            clbu_tail_sob,
    input  logic                            clbu_tail_eob,
    input  logic                            clbu_tail_sol,
    input  logic                            clbu_tail_eol,
    input  logic [BPBS_ID_W-1:0]            clbu_tail_pbs_id,
    input  logic                            clbu_tail_ntt_bwd,
    input  logic                            clbu_tail_ctrl_avail,
    output logic [PSI-1:0][R-1:0][OP_W-1:0] ntt_acc_data,
    output logic [PSI-1:0][R-1:0]           ntt_acc_data_vld,
    input  logic [PSI-1:0][R-1:0]           ntt_acc_data_rdy,
    output logic                            ntt_acc_sob,
    output logic                            ntt_acc_eob,
    output logic                            ntt_acc_sol,
    output logic                            ntt_acc_eol,
    output logic [BPBS_ID_W-1:0]            ntt_acc_pbs_id,
    output logic                            ntt_acc_ntt_bwd,
    output logic                            ntt_acc_ctrl_vld,
    input  logic                            ntt_acc_ctrl_rdy,
    output logic                            tail_almost_full,
    output logic                            tail_ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 2;

    typedef struct packed {
        logic [PSI-1:0][R-1:0][OP_W-1:0] data;
        logic                            sob;
        logic                            eob;
        logic                            sol;
        logic                            eol;
        logic [BPBS_ID_W-1:0]            pbs_id;
        logic                            ntt_bwd;
    } entry_t;

    entry_t                  mem [DEPTH];
    entry_t                  in_e;
    entry_t                  head;
    entry_t                  out_e;
    logic [AW:0]             wptr;
    logic [AW:0]             rptr;
    logic [AW:0]             fcnt;
    logic [OW-1:0]           occ;
    logic [OW-1:0]           occ_nxt;
    logic                    push;
    logic                    wr_en;
    logic                    f_rd;
    logic                    f_empty;
    logic                    f_full;
    logic                    full;
    logic                    out_empty;
    logic                    pop;
    logic [PSI-1:0][R-1:0]   sent;
    logic [PSI-1:0][R-1:0]   fire;
    logic                    ctrl_sent;
    logic                    ctrl_fire;

    assign in_e = '{data: clbu_tail_data, sob: clbu_tail_sob,
                    eob: clbu_tail_eob, sol: clbu_tail_sol,
                    eol: clbu_tail_eol, pbs_id: clbu_tail_pbs_id,
                    ntt_bwd: clbu_tail_ntt_bwd};

    assign push    = clbu_tail_ctrl_avail;
    assign f_empty = (wptr == rptr);
    assign f_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign fcnt    = wptr - rptr;
    assign head    = f_empty ? '0 : mem[rptr[AW-1:0]];
    // A push into a full buffer is kept only if the head leaves in the same cycle
    assign wr_en   = push && (!full || pop);
    assign occ_nxt = occ + OW'(wr_en) - OW'(pop);

`ifdef NTT_TAIL_OUTBUF_OUT_REG_EN
    entry_t     sk0;
    entry_t     sk1;
    logic [1:0] sk_cnt;

    assign f_rd      = !f_empty && (sk_cnt != 2'd2 || pop);
    assign out_empty = (sk_cnt == 2'd0);
    assign out_e     = sk0;
    assign occ       = {1'b0, fcnt} + OW'(sk_cnt);
    assign full      = (occ >= OW'(DEPTH));

    always_ff @(posedge clk) begin
        if (s_rst) begin
            sk0    <= '0;
            sk1    <= '0;
            sk_cnt <= 2'd0;
        end else begin
            unique case ({pop, f_rd})
                2'b01: begin
                    if (sk_cnt == 2'd0) sk0 <= head;
                    else                sk1 <= head;
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b10: begin
                    sk0    <= (sk_cnt == 2'd2) ? sk1 : '0;
                    sk1    <= '0;
                    sk_cnt <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd2) begin
                        sk0 <= sk1;
                        sk1 <= head;
                    end else begin
                        sk0 <= head;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign f_rd      = pop;
    assign out_empty = f_empty;
    assign out_e     = head;
    assign occ       = {1'b0, fcnt};
    assign full      = f_full;
`endif

    assign ntt_acc_data     = out_e.data;
    assign ntt_acc_sob      = out_e.sob;
    assign ntt_acc_eob      = out_e.eob;
    assign ntt_acc_sol      = out_e.sol;
    assign ntt_acc_eol      = out_e.eol;
    assign ntt_acc_pbs_id   = out_e.pbs_id;
    assign ntt_acc_ntt_bwd  = out_e.ntt_bwd;
    assign ntt_acc_data_vld = out_empty ? '0 : ~sent;
    assign ntt_acc_ctrl_vld = !out_empty && !ctrl_sent;

    assign fire      = ntt_acc_data_vld & ntt_acc_data_rdy;
    assign ctrl_fire = ntt_acc_ctrl_vld && ntt_acc_ctrl_rdy;
    assign pop       = !out_empty && (&(sent | fire)) && (ctrl_sent || ctrl_fire);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= in_e;
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            wptr             <= '0;
            rptr             <= '0;
            sent             <= '0;
            ctrl_sent        <= 1'b0;
            tail_almost_full <= 1'b0;
            tail_ovf_err     <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (f_rd)  rptr <= rptr + 1'b1;
            if (pop) begin
                sent      <= '0;
                ctrl_sent <= 1'b0;
            end else begin
                sent      <= sent | fire;
                ctrl_sent <= ctrl_sent || ctrl_fire;
            end
            if (push && !wr_en) tail_ovf_err <= 1'b1;
            tail_almost_full <= (occ_nxt >= OW'(DEPTH - AF_MARGIN));
        end
    end

    a_avail_match: assert property (@(posedge clk) disable iff (s_rst)
        clbu_tail_data_avail == {PSI{clbu_tail_ctrl_avail}});

endmodule
